sr_latch_driver: RTL

- Synchronous driver that produces the S/R inputs of an external cross-coupled NOR SR latch.
- Turns a valid/ready write request ("make q = value") into one clean set or reset pulse.
- Never asserts s and r together. Holds a guard gap after each pulse.
- Tracks the expected latch state and checks it against the synchronized latch output. Sits between control logic and a latch cell.

---
 rtl/sr_drv_pkg.sv | 4 +
 rtl/sync_2ff.sv | 19 +
 rtl/sr_latch_driver.sv | 94 +++++++++
 3 files changed

// File: rtl/sr_drv_pkg.sv
// Shared types for the SR latch driver.
package sr_drv_pkg;
  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; both flops clear to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic r_meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      q      <= 1'b0;
    end else begin
      r_meta <= d;
      q      <= r_meta;
    end
  end
endmodule

// File: rtl/sr_latch_driver.sv
// Drives S/R of an external NOR latch: one clean pulse per write request,
// a guard gap afterwards, and a read-back check of the latch output.
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int   PULSE_W = 4,
  parameter int   GAP_W   = 3,
  parameter logic INIT_Q  = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_valid,
  output logic req_ready,
  input  logic req_value,
  input  logic req_force,
  output logic s,
  output logic r,
  input  logic q_in,
  output logic q_expect,
  output logic done,
  output logic err,
  input  logic err_clr
);
  localparam int CNT_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             w_q_sync;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (q_in),
    .q     (w_q_sync)
  );

  assign req_ready = (r_state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      s        <= 1'b0;
      r        <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      q_expect <= INIT_Q;
    end else begin
      done <= 1'b0;
      // A mismatch in the GAP branch below overrides this clear.
      if (err_clr) err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            if (req_force || (req_value != q_expect)) begin
              r_state  <= PULSE;
              r_cnt    <= CNT_W'(PULSE_W - 1);
              q_expect <= req_value;
              s        <= req_value;
              r        <= ~req_value;
            end else begin
              done <= 1'b1;
            end
          end
        end
        PULSE: begin
          if (r_cnt == '0) begin
            r_state <= GAP;
            r_cnt   <= CNT_W'(GAP_W - 1);
            s       <= 1'b0;
            r       <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        GAP: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
            done    <= 1'b1;
            if (w_q_sync != q_expect) err <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          s       <= 1'b0;
          r       <= 1'b0;
        end
      endcase
    end
  end
endmodule
